// File: rtl/fifo_pkg.sv
// Shared types and sizing for the FIFO read-side consumer.
package fifo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } rd_state_t;

  localparam int unsigned BUF_DEPTH = 2;
  localparam int unsigned OCC_W     = 2;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry circular buffer that holds popped words until the stream sink accepts them.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [OCC_W-1:0] occ_o
);

  logic [WIDTH-1:0] mem_q [BUF_DEPTH];
  logic             wr_q, wr_d;
  logic             rd_q, rd_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             push_ok, pop_ok;

  // A push into a full buffer is only taken when the head leaves in the same cycle.
  always_comb begin
    pop_ok  = pop_i && (occ_q != '0);
    push_ok = push_i && ((occ_q != OCC_W'(BUF_DEPTH)) || pop_ok);
    wr_d    = wr_q ^ push_ok;
    rd_d    = rd_q ^ pop_ok;
    occ_d   = occ_q;
    if (push_ok && !pop_ok) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (!push_ok && pop_ok) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      occ_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= push_data_i;
      end
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      occ_q <= occ_d;
    end
  end

  assign head_o = mem_q[rd_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_pop_reader.sv
// Pops words from the FIFO read port, captures them a cycle later and replays them on a
// valid/ready stream through a two-entry buffer so back-pressure never drops a word.
module fifo_pop_reader
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             fifo_empty,
  output logic             fifo_pop,
  input  logic [WIDTH-1:0] fifo_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic [CNT_W-1:0] word_cnt,
  output logic             busy
);

  localparam int unsigned LOAD_W = OCC_W + 1;

  rd_state_t        state_q, state_d;
  logic             inflight_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OCC_W-1:0] occ;
  logic             accept;
  logic [LOAD_W-1:0] load;

  assign m_valid = (occ != '0);
  assign accept  = m_valid && m_ready;

  // Words already owed to the buffer after this cycle's beat leaves; a pop needs a free slot.
  assign load = LOAD_W'(occ) + LOAD_W'(inflight_q) - LOAD_W'(accept);

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    busy     = 1'b0;
    cnt_d    = cnt_q + CNT_W'(accept);
    case (state_q)
      IDLE: begin
        if (en) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (!en) begin
          state_d = STOP;
        end else begin
          fifo_pop = !fifo_empty && (load < LOAD_W'(BUF_DEPTH));
        end
      end
      STOP: begin
        busy = inflight_q || (occ != '0);
        if (en) begin
          state_d = RUN;
        end else if (!busy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= fifo_pop;
      cnt_q      <= cnt_d;
    end
  end

  assign word_cnt = cnt_q;

  fifo_skid_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .push_i     (inflight_q),
    .push_data_i(fifo_out),
    .pop_i      (accept),
    .head_o     (m_data),
    .occ_o      (occ)
  );

endmodule

// File: tb/tb_fifo_pop_reader.sv
// Bench for fifo_pop_reader: a 5-deep FIFO model feeds the reader; a queue of
// popped-but-undelivered words predicts pops, stream beats, counters and busy.
module tb_fifo_pop_reader;

  localparam int unsigned W = 4;

  logic         clk = 1'b0;
  logic         rst, en, fifo_empty, m_ready;
  logic [W-1:0] fifo_out;
  logic         fifo_pop, m_valid, busy;
  logic [W-1:0] m_data;
  logic [2:0]   word_cnt;
  logic         fifo_pop8, m_valid8, busy8;
  logic [W-1:0] m_data8;
  logic [7:0]   word_cnt8;

  always #5 clk = ~clk;

  fifo_pop_reader #(.WIDTH(W), .CNT_W(3)) u_dut (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
    .fifo_out(fifo_out), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .word_cnt(word_cnt), .busy(busy)
  );

  fifo_pop_reader #(.WIDTH(W), .CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop8),
    .fifo_out(fifo_out), .m_valid(m_valid8), .m_ready(m_ready), .m_data(m_data8),
    .word_cnt(word_cnt8), .busy(busy8)
  );

  typedef struct {
    logic [W-1:0] w;
    int           c;
  } ent_t;

  ent_t         held[$];     // words popped by the reader, not yet delivered
  logic [W-1:0] fq[$];       // FIFO contents
  logic [W-1:0] feed[$];     // words the writer still has to push
  logic [W-1:0] out_log[$];  // words delivered downstream
  logic [W-1:0] in_log[$];
  int n_cmp, n_bad, cyc, delivered, pops_seen;
  bit en_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    held.delete();
    delivered = 0;
    en_prev   = 1'b0;
  endtask

  task automatic load_fifo(input int n);
    fq.delete();
    feed.delete();
    out_log.delete();
    for (int i = 1; i <= n; i++) fq.push_back(W'(i));
    fifo_empty = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, then advance FIFO and model after the rising edge.
  task automatic tick();
    bit vexp, aexp, pexp, bexp, pop_obs;
    logic [W-1:0] d_obs;
    @(negedge clk);
    vexp = !rst && (held.size() > 0) && (held[0].c <= cyc - 2);
    aexp = vexp && m_ready;
    pexp = !rst && en_prev && en && (fq.size() > 0) && ((held.size() - (aexp ? 1 : 0)) < 2);
    bexp = !rst && (en_prev || (held.size() > 0));
    pop_obs = fifo_pop;
    d_obs   = m_data;
    chk("fifo_pop", 32'(fifo_pop), 32'(pexp));
    chk("m_valid", 32'(m_valid), 32'(vexp));
    chk("m_valid8", 32'(m_valid8), 32'(vexp));
    if (vexp) chk("m_data", 32'(m_data), 32'(held[0].w));
    chk("word_cnt", 32'(word_cnt), 32'(delivered % 8));
    chk("word_cnt8", 32'(word_cnt8), 32'(delivered % 256));
    chk("busy", 32'(busy), 32'(bexp));
    @(posedge clk);
    #1;
    if (rst) begin
      model_clear();
    end else begin
      if (aexp) begin
        void'(held.pop_front());
        out_log.push_back(d_obs);
        delivered++;
      end
      if (pop_obs && fq.size() > 0) begin
        fifo_out = fq.pop_front();
        held.push_back('{fifo_out, cyc});
        pops_seen++;
      end
      en_prev = en;
    end
    if (feed.size() > 0 && fq.size() < 5) fq.push_back(feed.pop_front());
    fifo_empty = (fq.size() == 0);
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_clear();
    chk("rst_pop", 32'(fifo_pop), 32'(0));
    chk("rst_valid", 32'(m_valid), 32'(0));
    chk("rst_cnt", 32'(word_cnt), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_mdata", 32'(m_data), 32'(0));
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_seq(input string tag, input int n);
    chk({tag, "_count"}, 32'(out_log.size()), 32'(n));
    for (int i = 0; i < out_log.size() && i < n; i++) chk(tag, 32'(out_log[i]), 32'(i + 1));
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0; pops_seen = 0;
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; fifo_out = '0;
    model_clear();

    // Full-rate stream of 1..5, then stop.
    do_reset();
    load_fifo(5);
    en = 1'b1; m_ready = 1'b1; pops_seen = 0;
    repeat (9) tick();
    chk("s1_pops", 32'(pops_seen), 32'(5));
    chk_seq("s1_data", 5);
    en = 1'b0;
    repeat (3) tick();
    chk("s1_busy_end", 32'(busy), 32'(0));

    // Sink stalled: only two pops, head held stable, then drain.
    do_reset();
    load_fifo(5);
    en = 1'b1; m_ready = 1'b0; pops_seen = 0;
    repeat (8) tick();
    chk("s2_pops", 32'(pops_seen), 32'(2));
    chk("s2_fifo_left", 32'(fq.size()), 32'(3));
    chk("s2_head", 32'(m_data), 32'(1));
    m_ready = 1'b1;
    repeat (10) tick();
    chk_seq("s2_data", 5);

    // Alternating ready.
    do_reset();
    load_fifo(5);
    en = 1'b1; m_ready = 1'b0;
    repeat (16) begin
      m_ready = ~m_ready;
      tick();
    end
    chk_seq("s3_data", 5);

    // en dropped one cycle after the first pop.
    do_reset();
    load_fifo(5);
    en = 1'b1; m_ready = 1'b1; pops_seen = 0;
    tick();
    tick();
    en = 1'b0;
    repeat (6) tick();
    chk("s4_pops", 32'(pops_seen), 32'(1));
    chk_seq("s4_data", 1);
    chk("s4_busy", 32'(busy), 32'(0));

    // Ten words through a 3-bit counter.
    do_reset();
    load_fifo(0);
    fifo_empty = 1'b1;
    for (int i = 1; i <= 10; i++) feed.push_back(W'(i));
    en = 1'b1; m_ready = 1'b1;
    repeat (20) tick();
    chk_seq("s5_data", 10);
    chk("s5_wrap", 32'(word_cnt), 32'(2));
    chk("s5_cnt8", 32'(word_cnt8), 32'(10));

    // Reset while a word is buffered and another is in flight.
    do_reset();
    load_fifo(5);
    en = 1'b1; m_ready = 1'b1;
    repeat (4) tick();
    do_reset();
    en = 1'b0;
    repeat (3) tick();
    chk("s6_valid", 32'(m_valid), 32'(0));

    // Random enable, ready and data.
    do_reset();
    load_fifo(0);
    fifo_empty = 1'b1;
    in_log.delete();
    for (int i = 0; i < 200; i++) begin
      feed.push_back(W'($urandom_range(0, 15)));
      in_log.push_back(feed[i]);
    end
    repeat (400) begin
      en      = ($urandom_range(0, 9) != 0);
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    en = 1'b1; m_ready = 1'b1;
    repeat (30) tick();
    chk("s7_count_nonzero", 32'(out_log.size() > 0), 32'(1));
    for (int i = 0; i < out_log.size(); i++) chk("s7_order", 32'(out_log[i]), 32'(in_log[i]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
